div_issue_ctrl: RTL
===================

# div_issue_ctrl

Sequencing stage directly upstream of the combinational M-extension divider in the RV32I execute path. It captures a DIV/DIVU/REM/REMU operation from decode and holds the operands and alucode stable at the divider inputs for a fixed number of cycles, which makes the divider a multicycle path. It stalls the front of the pipeline for that time, then registers the divider output and presents it to writeback with its destination register tag.

## Interface
- `LATENCY`, default 4: cycles operands are held before the result is sampled; legal range 1..16.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `valid_in`  in  1  decode presents a valid instruction this cycle.
- `alucode_in`  in  6  ALU code from decode (`ALU_*` encodings).
- `op1_in`, `op2_in`  in  32 each  source operands.
- `rd_in`  in  5  destination register.
- `flush`  in  1  pipeline flush; kills any in-flight operation.
- `div_alucode`  out  6  to divider; held value.
- `div_op1`, `div_op2`  out  32 each  to divider; held values.
- `div_result`  in  32  combinational result from divider.
- `stall`  out  1  freeze decode/fetch.
- `result_valid`  out  1  one-cycle pulse; `result` and `result_rd` are valid.
- `result`  out  32  registered quotient or remainder.
- `result_rd`  out  5  destination register tag for `result`.

## Operation
- `start` = `valid_in` & (`alucode_in` ∈ {DIV, DIVU, REM, REMU}) & `state==IDLE` & !`flush`. Other alucodes are ignored.
- States:
  - IDLE: on `start`, latch `alucode_in`, `op1_in`, `op2_in` and `rd_in`; load `cnt` with `LATENCY-1`; go to BUSY.
  - BUSY: if `cnt`≠0, decrement. If `cnt`==0, sample `div_result` into `result`, copy the latched rd to `result_rd`, and go to DONE.
  - DONE: `result_valid`=1 for exactly this cycle, then go to IDLE.
- `stall` = (`state==IDLE` & `start`) | (`state==BUSY`). The stall is combinational in the issue cycle and is deasserted in DONE, so the stalled instruction advances as the result is presented.
- `div_*` outputs always drive the latched registers. They change only on `start`.
- `flush` in any state forces IDLE at the next edge. No `result_valid` is produced for the killed operation. Latched operands may keep their values.
- A `valid_in` div-class instruction arriving while BUSY or DONE is not accepted. Upstream holds it because `stall` is high, or because it re-presents the instruction in the cycle after DONE.
- Divide-by-zero and overflow cases are resolved inside the divider; this block treats every operation identically.
- `cnt` width is `$clog2(LATENCY)` with a minimum of 1. With LATENCY=1, BUSY lasts one cycle.

## Timing
- Reset, asynchronous, `rst_n`=0: state=IDLE, `cnt`=0, `stall`=0, `result_valid`=0, `result`=0, `result_rd`=0, `div_alucode`=0, `div_op1`=0, `div_op2`=0.
- Assertion during an operation aborts it immediately; no result is produced.
- Issue in cycle N gives: `stall` high for cycles N..N+LATENCY, `result_valid` high in cycle N+LATENCY+1, and the next operation can be accepted in cycle N+LATENCY+2.
- `div_op*` are stable from N+1 through N+LATENCY+1. `div_result` is sampled at the end of cycle N+LATENCY.
- `flush` and `start` asserted in the same cycle: flush wins and nothing is latched.

## Structure
- Shared package `md_pkg`:
  - `state_t` enum {IDLE, BUSY, DONE}.
  - Function `is_div_class(alucode)` built on the `ALU_DIV`/`ALU_DIVU`/`ALU_REM`/`ALU_REMU` codes from `define.vh`.
  - Constant `MD_MAX_LATENCY`=16.
- One module, no sub-modules. The bench instantiates `div_issue_ctrl` together with the existing divider.

## Test plan
- DIV, op1=20, op2=0xFFFFFFFD (−3), rd=5, LATENCY=4, issued cycle N:
  - `stall` high N..N+4.
  - `result_valid` at N+5 with `result`=0xFFFFFFFA and `result_rd`=5.
- DIVU, op2=0 → `result`=0xFFFFFFFF. REMU, op1=7, op2=0 → `result`=7.
- REM, op1=0x80000000, op2=0xFFFFFFFF → `result`=0. DIV with the same operands → 0x80000000.
- Back-to-back DIV then REM presented continuously:
  - The second is accepted exactly at N+6.
  - Each produces one `result_valid` pulse.
  - `div_op*` never change while BUSY.
- `flush` at N+2 → IDLE at N+3, `stall` low, no `result_valid`. A following ADD (non-div) causes no stall.
- `rst_n` pulled low at N+2 (async, mid-cycle) → all outputs 0 immediately. After release, a DIVU 100/7 completes normally with `result`=14.

Source files
------------

// File: rtl/md_pkg.sv
// Shared M-extension definitions: ALU codes used by the multiply/divide path,
// sequencer state encoding and the divider issue helpers.
package md_pkg;

  // Mirrors the ALU_* encodings of the core's define.vh.
  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_SUB    = 6'd1;
  localparam logic [5:0] ALU_MUL    = 6'd24;
  localparam logic [5:0] ALU_MULH   = 6'd25;
  localparam logic [5:0] ALU_MULHSU = 6'd26;
  localparam logic [5:0] ALU_MULHU  = 6'd27;
  localparam logic [5:0] ALU_DIV    = 6'd28;
  localparam logic [5:0] ALU_DIVU   = 6'd29;
  localparam logic [5:0] ALU_REM    = 6'd30;
  localparam logic [5:0] ALU_REMU   = 6'd31;

  localparam int unsigned MD_MAX_LATENCY = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_div_class(input logic [5:0] alucode);
    return (alucode == ALU_DIV) || (alucode == ALU_DIVU) ||
           (alucode == ALU_REM) || (alucode == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Holds DIV/DIVU/REM/REMU operands stable at the combinational divider for LATENCY
// cycles, stalls the front end meanwhile, then registers the result for writeback.
module div_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [5:0]  alucode_in,
  input  logic [31:0] op1_in,
  input  logic [31:0] op2_in,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic [5:0]  div_alucode,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [31:0] div_result,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [4:0]      rd_q;
  logic            start;

  assign start = valid_in & is_div_class(alucode_in) & (state == IDLE) & ~flush;
  // Combinational in the issue cycle so decode freezes on the same edge the op is latched.
  assign stall = start | (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_q         <= '0;
      div_alucode  <= '0;
      div_op1      <= '0;
      div_op2      <= '0;
      result       <= '0;
      result_rd    <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      // Latched operands are left as-is; only the sequencing is killed.
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            div_alucode <= alucode_in;
            div_op1     <= op1_in;
            div_op2     <= op2_in;
            rd_q        <= rd_in;
            cnt         <= CntLoad;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            result       <= div_result;
            result_rd    <= rd_q;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
